next_queue_scroll_driver: RTL and testbench



---
 rtl/next_queue_scroll_driver_pkg.sv | 54 +++++
 rtl/next_queue_scroll_driver_if.sv | 23 ++
 rtl/next_queue_scroll_driver_render.sv | 37 +++
 rtl/next_queue_scroll_driver.sv | 139 +++++++++++++
 tb/tb_next_queue_scroll_driver.sv | 234 +++++++++++++++++++++++
 5 files changed

// File: rtl/next_queue_scroll_driver_pkg.sv
// Shared types, panel geometry and palette for the next-piece preview panel.
package next_queue_scroll_driver_pkg;

  typedef enum logic [3:0] {
    TILE_BLANK   = 4'd0,
    TILE_I       = 4'd1,
    TILE_O       = 4'd2,
    TILE_T       = 4'd3,
    TILE_J       = 4'd4,
    TILE_L       = 4'd5,
    TILE_S       = 4'd6,
    TILE_Z       = 4'd7,
    TILE_GARBAGE = 4'd8
  } tile_type_t;

  localparam int NEXT_PIECES_COUNT = 5;
  localparam int NEXT_SLOT_ROWS    = 3;
  localparam int NEXT_SCROLL_STEP  = 4;

  localparam int TILE_HEIGHT = 20;
  localparam int TILE_WIDTH  = 20;
  localparam int NEXT_ROWS   = NEXT_SLOT_ROWS * NEXT_PIECES_COUNT + 2;
  localparam int NEXT_COLS   = 6;
  localparam int NEXT_VSTART = 40;
  localparam int NEXT_HSTART = 460;

  typedef logic [1:0] next_scroll_state_t;
  localparam next_scroll_state_t NEXT_IDLE    = 2'd0;
  localparam next_scroll_state_t NEXT_PENDING = 2'd1;
  localparam next_scroll_state_t NEXT_SCROLL  = 2'd2;

  localparam logic [23:0] TILE_BLANK_COLOR       = 24'h000000;
  localparam logic [23:0] TETROMINO_I_COLOR      = 24'h00FFFF;
  localparam logic [23:0] TETROMINO_O_COLOR      = 24'hFFFF00;
  localparam logic [23:0] TETROMINO_T_COLOR      = 24'h800080;
  localparam logic [23:0] TETROMINO_J_COLOR      = 24'h0000FF;
  localparam logic [23:0] TETROMINO_L_COLOR      = 24'hFFA500;
  localparam logic [23:0] TETROMINO_S_COLOR      = 24'h00FF00;
  localparam logic [23:0] TETROMINO_Z_COLOR      = 24'hFF0000;

  function automatic logic [23:0] color_of(input tile_type_t t);
    case (t)
      TILE_I:  return TETROMINO_I_COLOR;
      TILE_O:  return TETROMINO_O_COLOR;
      TILE_T:  return TETROMINO_T_COLOR;
      TILE_J:  return TETROMINO_J_COLOR;
      TILE_L:  return TETROMINO_L_COLOR;
      TILE_S:  return TETROMINO_S_COLOR;
      TILE_Z:  return TETROMINO_Z_COLOR;
      default: return TILE_BLANK_COLOR;
    endcase
  endfunction

endpackage

// File: rtl/next_queue_scroll_driver_if.sv
// Pixel/queue bus between the VGA top (master) and the next-queue driver (slave).
interface next_queue_scroll_driver_if #(
  parameter int NEXT_COUNT = next_queue_scroll_driver_pkg::NEXT_PIECES_COUNT
) ();
  logic [9:0]                              VGA_row;
  logic [9:0]                              VGA_col;
  logic                                    frame_start;
  logic                                    queue_shift;
  next_queue_scroll_driver_pkg::tile_type_t pieces_queue [NEXT_COUNT];
  logic [2:0]                              show_count;
  logic [23:0]                             output_color;
  logic                                    active;

  modport master (
    output VGA_row, VGA_col, frame_start, queue_shift, pieces_queue, show_count,
    input  output_color, active
  );

  modport slave (
    input  VGA_row, VGA_col, frame_start, queue_shift, pieces_queue, show_count,
    output output_color, active
  );
endinterface

// File: rtl/next_queue_scroll_driver_render.sv
// Tile coordinates of the four cells of a tetromino in orientation 0 placed at a slot origin.
module next_queue_scroll_driver_render
  import next_queue_scroll_driver_pkg::*;
#(
  parameter int TW = 5
) (
  input  tile_type_t           piece,
  input  logic [TW-1:0]        origin_r,
  input  logic [TW-1:0]        origin_c,
  output logic                 drawn,
  output logic [3:0][TW-1:0]   cell_r,
  output logic [3:0][TW-1:0]   cell_c
);
  logic [3:0][1:0] dr;
  logic [3:0][1:0] dc;

  // The I piece sits one row lower so it is vertically centred in its slot.
  always_comb begin
    drawn = 1'b1;
    dr    = '0;
    dc    = '0;
    case (piece)
      TILE_I: begin dr = {2'd1, 2'd1, 2'd1, 2'd1}; dc = {2'd3, 2'd2, 2'd1, 2'd0}; end
      TILE_O: begin dr = {2'd1, 2'd1, 2'd0, 2'd0}; dc = {2'd2, 2'd1, 2'd2, 2'd1}; end
      TILE_T: begin dr = {2'd1, 2'd0, 2'd0, 2'd0}; dc = {2'd1, 2'd2, 2'd1, 2'd0}; end
      TILE_J: begin dr = {2'd1, 2'd1, 2'd1, 2'd0}; dc = {2'd2, 2'd1, 2'd0, 2'd0}; end
      TILE_L: begin dr = {2'd1, 2'd1, 2'd1, 2'd0}; dc = {2'd2, 2'd1, 2'd0, 2'd2}; end
      TILE_S: begin dr = {2'd1, 2'd1, 2'd0, 2'd0}; dc = {2'd1, 2'd0, 2'd2, 2'd1}; end
      TILE_Z: begin dr = {2'd1, 2'd1, 2'd0, 2'd0}; dc = {2'd2, 2'd1, 2'd1, 2'd0}; end
      default: drawn = 1'b0;
    endcase
    for (int k = 0; k < 4; k++) begin
      cell_r[k] = origin_r + TW'(dr[k]);
      cell_c[k] = origin_c + TW'(dc[k]);
    end
  end
endmodule

// File: rtl/next_queue_scroll_driver.sv
// Next-piece preview panel: scroll FSM plus a 2-stage pixel pipeline (tile/hit lookup, then colour).
module next_queue_scroll_driver
  import next_queue_scroll_driver_pkg::*;
#(
  parameter int NEXT_COUNT  = NEXT_PIECES_COUNT,
  parameter int SLOT_ROWS   = NEXT_SLOT_ROWS,
  parameter int SCROLL_STEP = NEXT_SCROLL_STEP
) (
  input  logic                     clk,
  input  logic                     rst,
  next_queue_scroll_driver_if.slave bus
);
  localparam int         TW          = 5;
  localparam int         SLOT_PX     = SLOT_ROWS * TILE_HEIGHT;
  localparam logic [9:0] OFFSET_LOAD = 10'(SLOT_PX - SCROLL_STEP);
  localparam logic [9:0] STEP        = 10'(SCROLL_STEP);

  function automatic logic [3:0] clamp_count(input logic [2:0] req);
    if (req == 3'd0) return 4'd1;
    if (int'(req) > NEXT_COUNT) return 4'(NEXT_COUNT);
    return {1'b0, req};
  endfunction

  next_scroll_state_t state_q, state_d;
  logic [9:0]         offset_q, offset_d;

  logic                    vld_p1_q, vld_p1_d, vld_p2_q, vld_p2_d;
  logic [NEXT_COUNT-1:0]   hit_p1_q, hit_p1_d;
  tile_type_t              sel_type_p1_q, sel_type_p1_d;
  logic                    in_panel_p1_q, in_panel_p1_d, in_panel_p2_q, in_panel_p2_d;
  logic [23:0]             color_p2_q, color_p2_d;

  logic signed [11:0] row_rel, col_rel, look_row;
  logic [TW-1:0]      tile_r, tile_c;
  logic               row_ok, col_ok;
  logic [3:0]         eff_count;

  logic                  slot_drawn [NEXT_COUNT];
  logic [3:0][TW-1:0]    cell_r     [NEXT_COUNT];
  logic [3:0][TW-1:0]    cell_c     [NEXT_COUNT];

  // Offset only moves on frame_start so a frame is never drawn with two offsets.
  always_comb begin
    state_d  = state_q;
    offset_d = offset_q;
    if (bus.queue_shift && bus.frame_start) begin
      state_d  = NEXT_SCROLL;
      offset_d = OFFSET_LOAD;
    end else if (bus.queue_shift) begin
      state_d = NEXT_PENDING;
    end else if (bus.frame_start) begin
      case (state_q)
        NEXT_PENDING: begin state_d = NEXT_SCROLL; offset_d = OFFSET_LOAD; end
        NEXT_SCROLL: begin
          offset_d = offset_q - STEP;
          if (offset_q <= STEP) begin state_d = NEXT_IDLE; offset_d = '0; end
        end
        default: ;
      endcase
    end
  end

  for (genvar i = 0; i < NEXT_COUNT; i++) begin : g_slot
    next_queue_scroll_driver_render #(.TW(TW)) u_render (
      .piece    (bus.pieces_queue[i]),
      .origin_r (TW'(SLOT_ROWS * i + 2)),
      .origin_c (TW'(2)),
      .drawn    (slot_drawn[i]),
      .cell_r   (cell_r[i]),
      .cell_c   (cell_c[i])
    );
  end

  // ---- stage 1: panel test, tile index by range comparators, per-slot hit
  always_comb begin
    eff_count     = clamp_count(bus.show_count);
    row_rel       = $signed({2'b00, bus.VGA_row}) - $signed(12'(NEXT_VSTART));
    col_rel       = $signed({2'b00, bus.VGA_col}) - $signed(12'(NEXT_HSTART));
    look_row      = row_rel - $signed({2'b00, offset_q});
    in_panel_p1_d = (row_rel >= 0) && (row_rel < $signed(12'(NEXT_ROWS * TILE_HEIGHT))) &&
                    (col_rel >= 0) && (col_rel < $signed(12'(NEXT_COLS * TILE_WIDTH)));
    tile_r = '0;
    tile_c = '0;
    row_ok = 1'b0;
    col_ok = 1'b0;
    for (int k = 0; k < NEXT_ROWS; k++)
      if (look_row >= $signed(12'(k * TILE_HEIGHT)) && look_row < $signed(12'((k + 1) * TILE_HEIGHT))) begin
        tile_r = TW'(k);
        row_ok = 1'b1;
      end
    for (int k = 0; k < NEXT_COLS; k++)
      if (col_rel >= $signed(12'(k * TILE_WIDTH)) && col_rel < $signed(12'((k + 1) * TILE_WIDTH))) begin
        tile_c = TW'(k);
        col_ok = 1'b1;
      end
    hit_p1_d      = '0;
    sel_type_p1_d = TILE_BLANK;
    for (int i = 0; i < NEXT_COUNT; i++)
      if (slot_drawn[i] && (4'(i) < eff_count) && row_ok && col_ok && in_panel_p1_d)
        for (int k = 0; k < 4; k++)
          if (cell_r[i][k] == tile_r && cell_c[i][k] == tile_c) hit_p1_d[i] = 1'b1;
    for (int i = NEXT_COUNT - 1; i >= 0; i--)
      if (hit_p1_d[i]) sel_type_p1_d = bus.pieces_queue[i];
    vld_p1_d = 1'b1;
  end

  // ---- stage 2: colour lookup
  always_comb begin
    color_p2_d    = (|hit_p1_q) ? color_of(sel_type_p1_q) : TILE_BLANK_COLOR;
    in_panel_p2_d = in_panel_p1_q;
    vld_p2_d      = vld_p1_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= NEXT_IDLE;
      offset_q <= '0;
      vld_p1_q <= 1'b0;
      vld_p2_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      offset_q <= offset_d;
      vld_p1_q <= vld_p1_d;
      vld_p2_q <= vld_p2_d;
    end
  end

  always_ff @(posedge clk) begin
    hit_p1_q      <= hit_p1_d;
    sel_type_p1_q <= sel_type_p1_d;
    in_panel_p1_q <= in_panel_p1_d;
    color_p2_q    <= color_p2_d;
    in_panel_p2_q <= in_panel_p2_d;
  end

  assign bus.output_color = vld_p2_q ? color_p2_q : TILE_BLANK_COLOR;
  assign bus.active       = vld_p2_q & in_panel_p2_q;

endmodule

// File: tb/tb_next_queue_scroll_driver.sv
// Bench for the next-queue preview driver: picture-level model checked every cycle plus pinned pixels.
module tb_next_queue_scroll_driver;
  import next_queue_scroll_driver_pkg::*;

  localparam int NC = 5;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_fail   = 0;
  bit   chk_en   = 1'b0;

  always #5 clk = ~clk;

  next_queue_scroll_driver_if #(.NEXT_COUNT(NC)) bus ();

  next_queue_scroll_driver #(.NEXT_COUNT(NC), .SLOT_ROWS(3), .SCROLL_STEP(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Picture of each piece in its slot: bit (r*4+c) set when tile (r,c) of the 2x4 box is filled.
  function automatic logic [7:0] shape_mask(input tile_type_t p);
    case (p)
      TILE_I:  return 8'b1111_0000;
      TILE_O:  return 8'b0110_0110;
      TILE_T:  return 8'b0010_0111;
      TILE_J:  return 8'b0111_0001;
      TILE_L:  return 8'b0111_0100;
      TILE_S:  return 8'b0011_0110;
      TILE_Z:  return 8'b0110_0011;
      default: return 8'h00;
    endcase
  endfunction

  function automatic logic [23:0] piece_rgb(input tile_type_t p);
    case (p)
      TILE_I:  return 24'h00FFFF;
      TILE_O:  return 24'hFFFF00;
      TILE_T:  return 24'h800080;
      TILE_J:  return 24'h0000FF;
      TILE_L:  return 24'hFFA500;
      TILE_S:  return 24'h00FF00;
      TILE_Z:  return 24'hFF0000;
      default: return 24'h000000;
    endcase
  endfunction

  function automatic bit model_in_panel(input int row, input int col);
    return row >= 40 && row < 40 + 17 * 20 && col >= 460 && col < 460 + 6 * 20;
  endfunction

  function automatic logic [23:0] model_color(input int row, input int col, input int show, input int off);
    int pr, pc, tr, tc, eff, dr, dc;
    logic [7:0] m;
    if (!model_in_panel(row, col)) return 24'h0;
    pr = row - 40 - off;
    pc = col - 460;
    if (pr < 0) return 24'h0;
    tr  = pr / 20;
    tc  = pc / 20;
    eff = (show == 0) ? 1 : ((show > NC) ? NC : show);
    for (int s = 0; s < eff; s++) begin
      dr = tr - (3 * s + 2);
      dc = tc - 2;
      m  = shape_mask(bus.pieces_queue[s]);
      if (dr >= 0 && dr < 2 && dc >= 0 && dc < 4)
        if (m[dr * 4 + dc]) return piece_rgb(bus.pieces_queue[s]);
    end
    return 24'h0;
  endfunction

  int          m_off  = 0;
  bit          m_pend = 1'b0;
  logic [23:0] p1_color = '0, p2_color = '0;
  bit          p1_act = 1'b0, p2_act = 1'b0, p1_vld = 1'b0, p2_vld = 1'b0;

  always @(posedge clk) begin
    p1_color <= model_color(int'(bus.VGA_row), int'(bus.VGA_col), int'(bus.show_count), m_off);
    p1_act   <= model_in_panel(int'(bus.VGA_row), int'(bus.VGA_col));
    p1_vld   <= !rst;
    p2_color <= p1_color;
    p2_act   <= p1_act;
    p2_vld   <= p1_vld && !rst;
    if (rst) begin
      m_off <= 0; m_pend <= 1'b0;
    end else if (bus.queue_shift && bus.frame_start) begin
      m_off <= 56; m_pend <= 1'b0;
    end else if (bus.queue_shift) begin
      m_pend <= 1'b1;
    end else if (bus.frame_start) begin
      if (m_pend) begin m_off <= 56; m_pend <= 1'b0; end
      else if (m_off > 0) m_off <= m_off - 4;
    end
  end

  function automatic logic [1:0] model_state();
    if (m_pend) return NEXT_PENDING;
    if (m_off > 0) return NEXT_SCROLL;
    return NEXT_IDLE;
  endfunction

  always @(negedge clk) begin
    if (chk_en) begin
      chk("cyc_color", 32'(bus.output_color), 32'(p2_vld ? p2_color : 24'h0));
      chk("cyc_active", 32'(bus.active), 32'(p2_vld && p2_act));
      chk("cyc_offset", 32'(dut.offset_q), 32'(m_off));
      chk("cyc_state", 32'(dut.state_q), 32'(model_state()));
    end
  end

  // All stimulus tasks start and end 2 time units after a rising edge.
  task automatic step(input bit fs, input bit qs);
    bus.frame_start = fs;
    bus.queue_shift = qs;
    @(posedge clk); #2;
    bus.frame_start = 1'b0;
    bus.queue_shift = 1'b0;
  endtask

  task automatic pix_check(input string name, input int row, input int col,
                           input logic [23:0] exp_c, input logic exp_a);
    bus.VGA_row = 10'(row);
    bus.VGA_col = 10'(col);
    @(posedge clk); @(posedge clk); #3;
    chk({name, "_color"}, 32'(bus.output_color), 32'(exp_c));
    chk({name, "_active"}, 32'(bus.active), 32'(exp_a));
    @(posedge clk); #2;
  endtask

  initial begin
    bus.VGA_row = '0; bus.VGA_col = '0;
    bus.frame_start = 1'b0; bus.queue_shift = 1'b0;
    bus.show_count = 3'd5;
    bus.pieces_queue[0] = TILE_T; bus.pieces_queue[1] = TILE_I; bus.pieces_queue[2] = TILE_O;
    bus.pieces_queue[3] = TILE_S; bus.pieces_queue[4] = TILE_Z;
    @(posedge clk); #2;
    chk_en = 1'b1;
    repeat (2) @(posedge clk);
    #2;
    chk("rst_color", 32'(bus.output_color), 32'h0);
    chk("rst_active", 32'(bus.active), 32'h0);
    chk("rst_offset", 32'(dut.offset_q), 32'd0);
    chk("rst_state", 32'(dut.state_q), 32'(NEXT_IDLE));
    rst = 1'b0;

    pix_check("t_slot0", 85, 505, 24'h800080, 1'b1);
    pix_check("i_slot1", 165, 505, 24'h00FFFF, 1'b1);
    pix_check("o_slot2", 205, 525, 24'hFFFF00, 1'b1);
    pix_check("z_slot4", 325, 505, 24'hFF0000, 1'b1);
    pix_check("outside", 10, 10, 24'h0, 1'b0);
    pix_check("empty_tile", 45, 465, 24'h0, 1'b1);

    bus.show_count = 3'd2;
    pix_check("show2_slot2", 205, 525, 24'h0, 1'b1);
    pix_check("show2_slot1", 165, 505, 24'h00FFFF, 1'b1);
    bus.show_count = 3'd0;
    pix_check("show0_slot1", 165, 505, 24'h0, 1'b1);
    pix_check("show0_slot0", 85, 505, 24'h800080, 1'b1);
    bus.show_count = 3'd7;
    pix_check("show7_slot4", 325, 505, 24'hFF0000, 1'b1);
    bus.show_count = 3'd5;

    step(1'b0, 1'b1);
    chk("shift_offset", 32'(dut.offset_q), 32'd0);
    chk("shift_state", 32'(dut.state_q), 32'(NEXT_PENDING));
    for (int k = 1; k <= 15; k++) begin
      step(1'b1, 1'b0);
      chk("scroll_offset", 32'(dut.offset_q), 32'(60 - 4 * k));
      chk("scroll_state", 32'(dut.state_q), 32'((k == 15) ? NEXT_IDLE : NEXT_SCROLL));
      if (k == 1) begin
        pix_check("off56_shifted_t", 141, 505, 24'h800080, 1'b1);
        pix_check("off56_above", 85, 505, 24'h0, 1'b1);
      end
    end

    step(1'b1, 1'b1);
    chk("simul_offset", 32'(dut.offset_q), 32'd56);
    chk("simul_state", 32'(dut.state_q), 32'(NEXT_SCROLL));
    repeat (7) step(1'b1, 1'b0);
    chk("at28_offset", 32'(dut.offset_q), 32'd28);
    step(1'b0, 1'b1);
    chk("reshift_offset", 32'(dut.offset_q), 32'd28);
    chk("reshift_state", 32'(dut.state_q), 32'(NEXT_PENDING));
    pix_check("pend28_t", 113, 505, 24'h800080, 1'b1);
    step(1'b0, 1'b0);
    chk("held_offset", 32'(dut.offset_q), 32'd28);
    step(1'b1, 1'b0);
    chk("reload_offset", 32'(dut.offset_q), 32'd56);
    chk("reload_state", 32'(dut.state_q), 32'(NEXT_SCROLL));

    repeat (6) step(1'b1, 1'b0);
    chk("at32_offset", 32'(dut.offset_q), 32'd32);
    pix_check("clip_lastrow_z", 379, 525, 24'hFF0000, 1'b1);
    pix_check("clip_below", 400, 505, 24'h0, 1'b0);

    bus.VGA_row = 10'd85;
    bus.VGA_col = 10'd505;
    rst = 1'b1;
    @(posedge clk); #2;
    rst = 1'b0;
    chk("midrst_offset", 32'(dut.offset_q), 32'd0);
    chk("midrst_state", 32'(dut.state_q), 32'(NEXT_IDLE));
    chk("midrst_color0", 32'(bus.output_color), 32'h0);
    chk("midrst_active0", 32'(bus.active), 32'h0);
    @(posedge clk); #2;
    chk("midrst_color1", 32'(bus.output_color), 32'h0);
    chk("midrst_active1", 32'(bus.active), 32'h0);
    @(posedge clk); #2;
    chk("postrst_color", 32'(bus.output_color), 32'h800080);
    chk("postrst_active", 32'(bus.active), 32'h1);

    @(negedge clk);
    chk_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "bench did not terminate");
  end

endmodule
